// File: rtl/cga_vga_doubler.sv
// CGA-to-VGA line doubler: each input scanline is captured at half rate into a
// ping-pong line buffer and replayed twice at double line rate.
module cga_vga_doubler #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned HSYNC_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_reset,
   input  logic [3:0]        video,
   output logic              dbl_hsync,
   output logic [3:0]        dbl_video,
   output logic [ADDR_W:0]   line_len
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] WADDR_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [3:0]        bank0 [DEPTH];
   logic [3:0]        bank1 [DEPTH];
   logic              wbank;
   logic              phase;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] wlast;
   logic [CNT_W-1:0]  in_cnt;
   logic [CNT_W-1:0]  raddr;
   logic [CNT_W-1:0]  raddr_d;
   logic [CNT_W-1:0]  half_len;
   logic [3:0]        rdata;
   logic              wr_en;
   logic              wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic              mid_clr;

   // Write port: the line_reset sample always opens the new bank at address 0.
   always_comb begin
      wr_en   = 1'b0;
      wr_bank = wbank;
      wr_addr = waddr;
      if (line_reset) begin
         wr_en   = 1'b1;
         wr_bank = ~wbank;
         wr_addr = '0;
      end else if (!phase && (waddr != WADDR_MAX)) begin
         wr_en = 1'b1;
      end
   end

   assign half_len = line_len >> 1;
   assign mid_clr  = (half_len != '0) && ((raddr + CNT_W'(1)) == half_len);

   // Line buffer banks; the read side always uses the bank not being written.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_bank) bank0[wr_addr] <= video;
      if (wr_en &&  wr_bank) bank1[wr_addr] <= video;
      rdata <= wbank ? bank0[raddr[ADDR_W-1:0]] : bank1[raddr[ADDR_W-1:0]];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wbank     <= 1'b0;
         phase     <= 1'b0;
         waddr     <= '0;
         wlast     <= '0;
         in_cnt    <= '0;
         line_len  <= '0;
         raddr     <= '0;
         // Out-of-range so the first cycle after reset emits neither sync nor data.
         raddr_d   <= '1;
         dbl_hsync <= 1'b0;
         dbl_video <= '0;
      end else begin
         phase  <= ~phase;
         in_cnt <= (in_cnt == CNT_MAX) ? in_cnt : in_cnt + CNT_W'(1);
         raddr  <= mid_clr ? '0 : raddr + CNT_W'(1);
         if (wr_en) waddr <= waddr + ADDR_W'(1);
         if (line_reset) begin
            wbank    <= ~wbank;
            phase    <= 1'b1;
            waddr    <= ADDR_W'(1);
            wlast    <= waddr;
            in_cnt   <= CNT_W'(1);
            line_len <= in_cnt;
            raddr    <= '0;
         end
         raddr_d   <= raddr;
         dbl_hsync <= raddr_d < CNT_W'(HSYNC_W);
         if (raddr_d[ADDR_W] || (raddr_d >= {1'b0, wlast})) dbl_video <= '0;
         else                                               dbl_video <= rdata;
      end
   end
endmodule

// File: tb/tb_cga_vga_doubler.sv
// Directed bench for cga_vga_doubler: line capture, double replay, saturation and reset cases.
module tb_cga_vga_doubler;
   logic        clk = 1'b0;
   logic        reset;
   logic        line_reset;
   logic [3:0]  video;
   logic        dbl_hsync;
   logic [3:0]  dbl_video;
   logic [10:0] line_len;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] ov [4096];
   logic       oh [4096];
   int ll;
   int cnt;

   cga_vga_doubler #(.ADDR_W(10), .HSYNC_W(64)) dut (
      .clk(clk), .reset(reset), .line_reset(line_reset), .video(video),
      .dbl_hsync(dbl_hsync), .dbl_video(dbl_video), .line_len(line_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      line_reset = 1'b0;
      video = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // One input line; ov/oh[k] hold the outputs seen just after the k-th edge of the line.
   task automatic run_line(input int len, input int off);
      for (int k = 0; k < len; k++) begin
         line_reset = (k == 0);
         video = 4'((k + off) % 16);
         @(posedge clk);
         #1;
         ov[k] = dbl_video;
         oh[k] = dbl_hsync;
         if (k == 0) ll = int'(line_len);
      end
      line_reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      line_reset = 1'b0;
      video = '0;
      #12;
      chk("rst_video", int'(dbl_video), 0);
      chk("rst_hsync", int'(dbl_hsync), 0);
      chk("rst_line_len", int'(line_len), 0);

      // Free-running after reset: hsync clk 2..65 repeating every 2048, video dark
      do_reset();
      cnt = 0;
      for (int n = 1; n <= 2050; n++) begin
         @(posedge clk);
         #1;
         if (dbl_video !== 4'd0) cnt++;
         if (n == 1 || n == 2 || n == 65 || n == 66 || n == 2049 || n == 2050)
            chk($sformatf("free_hsync_n%0d", n), int'(dbl_hsync),
                (((n - 2 + 2048) % 2048) < 64) ? 1 : 0);
      end
      chk("free_video_dark", cnt, 0);

      // 912-clk lines: second line replays even samples twice
      do_reset();
      run_line(912, 0);
      run_line(912, 0);
      chk("l912_len", ll, 912);
      chk("l912_v2", int'(ov[2]), 0);
      chk("l912_v3", int'(ov[3]), 2);
      chk("l912_v11", int'(ov[11]), 2);
      chk("l912_v457", int'(ov[457]), 14);
      chk("l912_v458", int'(ov[458]), 0);
      chk("l912_v459", int'(ov[459]), 2);
      chk("l912_h65", int'(oh[65]), 1);
      chk("l912_h66", int'(oh[66]), 0);
      chk("l912_h458", int'(oh[458]), 1);
      chk("l912_h521", int'(oh[521]), 1);
      chk("l912_h522", int'(oh[522]), 0);

      // 3000-clk lines: counters saturate, early entries survive
      do_reset();
      run_line(3000, 1);
      run_line(3000, 1);
      chk("sat_len", ll, 2047);
      chk("sat_v2", int'(ov[2]), 1);
      chk("sat_v3", int'(ov[3]), 3);
      chk("sat_v1024", int'(ov[1024]), 13);
      chk("sat_v1025", int'(ov[1025]), 1);
      chk("sat_h1025", int'(oh[1025]), 1);

      // line_reset with a 1-cycle gap: sample lands at address 0 of the new bank
      run_line(912, 0);
      run_line(2, 5);
      run_line(912, 0);
      chk("gap_len", ll, 2);
      chk("gap_v2", int'(ov[2]), 5);
      chk("gap_v100", int'(ov[100]), 5);
      chk("gap_h100", int'(oh[100]), 1);

      // Reset mid-line: first doubled line dark, second correct
      do_reset();
      run_line(300, 0);
      do_reset();
      run_line(912, 0);
      cnt = 0;
      for (int k = 2; k < 912; k++) if (ov[k] !== 4'd0) cnt++;
      chk("rstmid_first_dark", cnt, 0);
      run_line(912, 0);
      chk("rstmid_len", ll, 912);
      chk("rstmid_v3", int'(ov[3]), 2);
      chk("rstmid_v457", int'(ov[457]), 14);

      // Odd period 911: halves of 455, hsync 64 clk each
      run_line(911, 0);
      run_line(911, 0);
      chk("odd_len", ll, 911);
      chk("odd_h65", int'(oh[65]), 1);
      chk("odd_h66", int'(oh[66]), 0);
      chk("odd_v456", int'(ov[456]), 12);
      chk("odd_v457", int'(ov[457]), 0);
      chk("odd_h457", int'(oh[457]), 1);
      chk("odd_v458", int'(ov[458]), 2);
      chk("odd_h520", int'(oh[520]), 1);
      chk("odd_h521", int'(oh[521]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
